// File: rtl/result_uart_tx.sv
// Serializes the argmax class index as an ASCII line (digit, CR, LF) on an 8N1 UART TX pin.
// Define RESULT_TX_PREFIX_EN to prepend "R:" to every line.
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 5209
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [3:0] class_idx,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_serial
);

`ifdef RESULT_TX_PREFIX_EN
    localparam int N_CHARS = 5;
    localparam int PTR_W   = 3;
`else
    localparam int N_CHARS = 3;
    localparam int PTR_W   = 2;
`endif

    localparam logic [15:0]      BAUD_MAX = 16'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_CHARS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        NEXT_CHAR,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [3:0]       idx_q, idx_d;
    logic [7:0]       byte_d;
    logic             bit_end;
    logic             tx_d, busy_d, done_d;

    function automatic logic [7:0] digit_char(input logic [3:0] idx);
        if (idx <= 4'd9) return 8'h30 + {4'h0, idx};
        return 8'h3F;
    endfunction

    function automatic logic [7:0] msg_byte(input logic [PTR_W-1:0] ptr, input logic [3:0] idx);
`ifdef RESULT_TX_PREFIX_EN
        case (ptr)
            3'd0:    return 8'h52;
            3'd1:    return 8'h3A;
            3'd2:    return digit_char(idx);
            3'd3:    return 8'h0D;
            default: return 8'h0A;
        endcase
`else
        case (ptr)
            2'd0:    return digit_char(idx);
            2'd1:    return 8'h0D;
            default: return 8'h0A;
        endcase
`endif
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            ptr_q     <= '0;
            idx_q     <= '0;
            tx_serial <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            tx_serial <= tx_d;
            busy      <= busy_d;
            tx_done   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        bit_end = (baud_q == BAUD_MAX);

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (start) begin
                    idx_d   = class_idx;
                    ptr_d   = '0;
                    state_d = START_BIT;
                end
            end
            START_BIT: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA_BITS;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA_BITS: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = STOP_BIT;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP_BIT: begin
                // The next-char decision is folded in here so the next start bit
                // follows the stop bit with no idle cycle on the line.
                if (bit_end) begin
                    baud_d = '0;
                    if (ptr_q != LAST_PTR) begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = START_BIT;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            NEXT_CHAR: state_d = IDLE;
            DONE: begin
                baud_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state and registered, keeping the pin glitch-free.
        byte_d = msg_byte(ptr_d, idx_d);
        case (state_d)
            START_BIT: tx_d = 1'b0;
            DATA_BITS: tx_d = byte_d[bit_d];
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d == START_BIT) || (state_d == DATA_BITS) || (state_d == STOP_BIT);
        done_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: cycle-exact line model plus a mid-bit sampling UART monitor.
module tb_result_uart_tx;
    localparam int C = 4;
`ifdef RESULT_TX_PREFIX_EN
    localparam int NCH = 5;
`else
    localparam int NCH = 3;
`endif
    localparam int ACTIVE = NCH * 10 * C;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       start = 1'b0;
    logic [3:0] class_idx = 4'd0;
    logic       busy, tx_done, tx_serial;

    int total = 0;
    int bad   = 0;
    logic [7:0] mon_q[$];
    int frame_err = 0;

    always #5 clk = ~clk;

    result_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .resetn(resetn), .start(start), .class_idx(class_idx),
        .busy(busy), .tx_done(tx_done), .tx_serial(tx_serial)
    );

    function automatic logic [7:0] ref_byte(input int idx, input int n);
        logic [7:0] d;
        d = (idx < 10) ? 8'(48 + idx) : 8'h3F;
`ifdef RESULT_TX_PREFIX_EN
        case (n)
            0: return 8'h52;
            1: return 8'h3A;
            2: return d;
            3: return 8'h0D;
            default: return 8'h0A;
        endcase
`else
        case (n)
            0: return d;
            1: return 8'h0D;
            default: return 8'h0A;
        endcase
`endif
    endfunction

    // Expected line level k cycles after the start edge: 10-bit frames of C cycles each.
    function automatic logic ref_line(input int idx, input int k);
        int ch, pos;
        logic [7:0] b;
        ch  = k / (10 * C);
        pos = (k / C) % 10;
        b   = ref_byte(idx, ch);
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos-1];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // UART receiver: samples the middle of each bit period.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge tx_serial);
            repeat (C / 2) @(posedge clk);
            #1;
            if (tx_serial !== 1'b0) frame_err++;
            for (int i = 0; i < 8; i++) begin
                repeat (C) @(posedge clk);
                #1;
                b[i] = tx_serial;
            end
            repeat (C) @(posedge clk);
            #1;
            if (tx_serial !== 1'b1) frame_err++;
            mon_q.push_back(b);
        end
    end

    task automatic run_msg(input int idx, input bit presend, input bit hold, input bit collide);
        int wave_err, busy_err, done_err;
        logic [31:0] got;
        wave_err = 0; busy_err = 0; done_err = 0;
        if (presend) begin
            @(negedge clk);
            chk("idle_busy", busy, 1'b0);
            start = 1'b1;
            class_idx = 4'(idx);
        end
        for (int k = 0; k < ACTIVE; k++) begin
            @(negedge clk);
            start = hold || (collide && k == 50);
            class_idx = (collide && k == 50) ? 4'd3 : 4'($urandom);
            if (tx_serial !== ref_line(idx, k)) wave_err++;
            if (busy !== 1'b1) busy_err++;
            if (tx_done !== 1'b0) done_err++;
        end
        chk("wave_errs", wave_err, 0);
        chk("busy_errs", busy_err, 0);
        chk("early_done", done_err, 0);
        @(negedge clk);
        chk("done_pulse", tx_done, 1'b1);
        chk("done_busy", busy, 1'b0);
        chk("done_line", tx_serial, 1'b1);
        chk("mon_count", mon_q.size(), NCH);
        for (int n = 0; n < NCH; n++) begin
            got = (n < mon_q.size()) ? 32'(mon_q[n]) : 32'hFFFF;
            chk("mon_byte", got, 32'(ref_byte(idx, n)));
        end
        chk("frame_err", frame_err, 0);
        mon_q.delete();
    endtask

    task automatic quiet(input int cycles);
        int errs;
        errs = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx_done !== 1'b0 || tx_serial !== 1'b1) errs++;
        end
        chk("quiet", errs, 0);
    endtask

    initial begin
        int seen_done;
        #1 resetn = 1'b0;
        #1;
        chk("rst_line", tx_serial, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        quiet(3);

        run_msg(7, 1'b1, 1'b0, 1'b0);
        quiet(4);
        run_msg(12, 1'b1, 1'b0, 1'b0);
        quiet(4);
        run_msg(7, 1'b1, 1'b0, 1'b1);
        quiet(10);
        for (int r = 0; r < 3; r++) begin
            run_msg(int'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0);
            quiet(2);
        end

        // Reset 20 cycles into an index-5 message.
        @(negedge clk);
        start = 1'b1;
        class_idx = 4'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("midrst_line", tx_serial, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", tx_done, 1'b0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx_done !== 1'b0) seen_done++;
        end
        chk("midrst_no_done", seen_done, 0);
        mon_q.delete();
        frame_err = 0;
        run_msg(0, 1'b1, 1'b0, 1'b0);
        quiet(4);

        // Start held high: DONE cycle plus one IDLE cycle between messages.
        run_msg(9, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        class_idx = 4'd9;
        chk("b2b_idle_busy", busy, 1'b0);
        chk("b2b_idle_done", tx_done, 1'b0);
        chk("b2b_idle_line", tx_serial, 1'b1);
        run_msg(9, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        @(negedge clk);
        quiet(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
